// File: rtl/fwd_hazard_pkg.sv
// Shared types and constants for the forwarding / hazard unit.
// Scoreboard entries carry the widest legal register address; narrower AW builds zero-extend.
package fwd_hazard_pkg;

  localparam int FHU_AW_MAX = 8;

  localparam int SEL_RF  = 0;
  localparam int SEL_MEM = 1;
  localparam int SEL_WB  = 2;

  typedef struct packed {
    logic                  valid;
    logic                  wb_en;
    logic [FHU_AW_MAX-1:0] dest;
    logic                  is_load;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request bundle and hazard/forwarding response for fwd_hazard_unit.
// The master side is the datapath; the slave side is the hazard unit.
interface fwd_hazard_unit_if #(
  parameter int AW      = 4,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int SEL_W   = $clog2(DEPTH),
  parameter int CNT_W   = 16
);

  logic                     fwd_en;
  logic                     flush;
  logic                     id_valid;
  logic [NUM_SRC*AW-1:0]    id_src;
  logic [NUM_SRC-1:0]       id_src_used;
  logic                     id_wb_en;
  logic                     id_mem_rd;
  logic [AW-1:0]            id_dest;
  logic                     stall;
  logic [NUM_SRC*SEL_W-1:0] exe_sel_src;
  logic [CNT_W-1:0]         stall_cnt;

  modport master (
    output fwd_en, flush, id_valid, id_src, id_src_used, id_wb_en, id_mem_rd, id_dest,
    input  stall, exe_sel_src, stall_cnt
  );

  modport slave (
    input  fwd_en, flush, id_valid, id_src, id_src_used, id_wb_en, id_mem_rd, id_dest,
    output stall, exe_sel_src, stall_cnt
  );

endinterface

// File: rtl/fwd_src_match.sv
// Priority matcher for one source operand against the shadow scoreboard.
// Produces the operand select and a stall request; the youngest matching stage wins.
module fwd_src_match
  import fwd_hazard_pkg::*;
#(
  parameter int AW    = 4,
  parameter int DEPTH = 3,
  parameter int SEL_W = $clog2(DEPTH)
) (
  input  logic             fwd_en,
  input  logic [AW-1:0]    src,
  input  logic             src_used,
  input  sb_entry_t        entry [1:DEPTH],
  output logic [SEL_W-1:0] sel,
  output logic             stall_req
);

  logic       hit;
  logic [2:0] hit_k;
  logic       hit_load;

  // Scan oldest to youngest so the lowest stage index is left standing.
  always_comb begin
    hit      = 1'b0;
    hit_k    = 3'd0;
    hit_load = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (src_used && entry[k].valid && entry[k].wb_en &&
          (entry[k].dest == FHU_AW_MAX'(src))) begin
        hit      = 1'b1;
        hit_k    = 3'(k);
        hit_load = entry[k].is_load;
      end
    end
  end

  // The oldest stage never forwards: the register file writes before it reads.
  always_comb begin
    sel       = SEL_W'(SEL_RF);
    stall_req = 1'b0;
    if (hit) begin
      if (!fwd_en) begin
        stall_req = (hit_k < 3'(DEPTH));
      end else if (hit_k == 3'd1) begin
        if (hit_load) stall_req = 1'b1;
        else          sel       = SEL_W'(SEL_MEM);
      end else if (hit_k == 3'd2 && DEPTH > 2) begin
        sel = SEL_W'(SEL_WB);
      end else if (hit_k < 3'(DEPTH)) begin
        sel = SEL_W'(hit_k);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit beside the ID/EXE register with its own shadow scoreboard
// of in-flight destinations, registered operand selects and a saturating stall counter.
module fwd_hazard_unit
  import fwd_hazard_pkg::*;
#(
  parameter int AW      = 4,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int SEL_W   = $clog2(DEPTH),
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  fwd_hazard_unit_if.slave   hz
);

  sb_entry_t                sb [1:DEPTH];
  sb_entry_t                new_entry;
  logic [NUM_SRC-1:0]       src_stall;
  logic [NUM_SRC*SEL_W-1:0] sel_next;
  logic [NUM_SRC*SEL_W-1:0] sel_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     stall;
  logic                     issue;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_match #(
      .AW    (AW),
      .DEPTH (DEPTH),
      .SEL_W (SEL_W)
    ) u_match (
      .fwd_en    (hz.fwd_en),
      .src       (hz.id_src[i*AW +: AW]),
      .src_used  (hz.id_src_used[i]),
      .entry     (sb),
      .sel       (sel_next[i*SEL_W +: SEL_W]),
      .stall_req (src_stall[i])
    );
  end

  // Flush dominates: a squashed instruction can neither stall nor issue.
  assign stall = hz.id_valid & ~hz.flush & (|src_stall);
  assign issue = hz.id_valid & ~stall & ~hz.flush;

  always_comb begin
    new_entry         = SB_BUBBLE;
    new_entry.valid   = 1'b1;
    new_entry.wb_en   = hz.id_wb_en;
    new_entry.dest    = FHU_AW_MAX'(hz.id_dest);
    new_entry.is_load = hz.id_mem_rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) sb[k] <= SB_BUBBLE;
    end else begin
      sb[1] <= issue ? new_entry : SB_BUBBLE;
      for (int k = 2; k <= DEPTH; k++) sb[k] <= sb[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_q <= '0;
    else        sel_q <= issue ? sel_next : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt_q <= '0;
    else if (stall && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
  end

  assign hz.stall       = stall;
  assign hz.exe_sel_src = sel_q;
  assign hz.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios plus random traffic
// compared against an issue-history reference model.
module tb_fwd_hazard_unit;

  localparam int AW      = 4;
  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 3;
  localparam int SEL_W   = $clog2(DEPTH);
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic          valid;
    logic          wb;
    logic          load;
    logic [AW-1:0] dest;
  } rec_t;

  logic clk;
  logic rst_n;

  fwd_hazard_unit_if #(
    .AW(AW), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .SEL_W(SEL_W), .CNT_W(CNT_W)
  ) hz_if ();

  fwd_hazard_unit #(
    .AW(AW), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .SEL_W(SEL_W), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  rec_t hist[$];
  int   cnt_e;

  task automatic check_val(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, got, want, $time);
    end
  endtask

  // hist holds one record per clock (bubble or issued instruction); the last element is the
  // instruction now in EXE, so the age of a producer is its distance from the back.
  function automatic void model(input logic v, input logic fl, input logic fwd,
                                input logic [NUM_SRC*AW-1:0] src,
                                input logic [NUM_SRC-1:0] used,
                                output logic st, output logic [NUM_SRC*SEL_W-1:0] sel);
    int   age;
    rec_t r;
    st  = 1'b0;
    sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      age = 0;
      if (used[i]) begin
        for (int a = 1; a <= DEPTH; a++) begin
          r = hist[hist.size() - a];
          if (age == 0 && r.valid && r.wb && r.dest == src[i*AW +: AW]) age = a;
        end
      end
      if (age != 0) begin
        if (!fwd) begin
          if (age < DEPTH) st = 1'b1;
        end else if (age == 1 && hist[hist.size() - 1].load) begin
          st = 1'b1;
        end else if (age < DEPTH) begin
          sel[i*SEL_W +: SEL_W] = SEL_W'(age);
        end
      end
    end
    st = st & v & ~fl;
  endfunction

  task automatic drive(input logic v, input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                       input logic [1:0] used, input logic wb, input logic ld,
                       input logic [AW-1:0] dest, input logic fwd, input logic fl);
    hz_if.id_valid    = v;
    hz_if.id_src      = {s1, s0};
    hz_if.id_src_used = used;
    hz_if.id_wb_en    = wb;
    hz_if.id_mem_rd   = ld;
    hz_if.id_dest     = dest;
    hz_if.fwd_en      = fwd;
    hz_if.flush       = fl;
  endtask

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < DEPTH; k++) hist.push_back(rec_t'('0));
    cnt_e = 0;
  endtask

  // Called at a falling edge; leaves reset released at the next falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 1, 0);
    #1;
    check_val("rst_stall", int'(hz_if.stall), 0);
    check_val("rst_sel", int'(hz_if.exe_sel_src), 0);
    check_val("rst_cnt", int'(hz_if.stall_cnt), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One ID cycle: drive at the falling edge, check stall, clock, check registered outputs.
  // want_st / want_sel are hand-derived scenario values; -1 skips that check.
  task automatic step(input logic v, input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                      input logic [1:0] used, input logic wb, input logic ld,
                      input logic [AW-1:0] dest, input logic fwd, input logic fl,
                      input int want_st, input int want_sel);
    logic                     st_e;
    logic                     iss;
    logic [NUM_SRC*SEL_W-1:0] sel_e;
    rec_t                     r;
    drive(v, s0, s1, used, wb, ld, dest, fwd, fl);
    #1;
    model(v, fl, fwd, {s1, s0}, used, st_e, sel_e);
    check_val("stall", int'(hz_if.stall), int'(st_e));
    if (want_st >= 0) check_val("spec_stall", int'(hz_if.stall), want_st);
    iss = v & ~st_e & ~fl;
    if (st_e && cnt_e != CNT_MAX) cnt_e++;
    @(posedge clk);
    #1;
    r.valid = iss;
    r.wb    = iss & wb;
    r.load  = iss & ld;
    r.dest  = iss ? dest : '0;
    hist.push_back(r);
    void'(hist.pop_front());
    check_val("exe_sel", int'(hz_if.exe_sel_src), iss ? int'(sel_e) : 0);
    if (want_sel >= 0) check_val("spec_sel", int'(hz_if.exe_sel_src), want_sel);
    check_val("stall_cnt", int'(hz_if.stall_cnt), cnt_e);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 1, 0);
    model_reset();
    @(negedge clk);
    do_reset();

    // ADD r1 ; SUB r2,r1,r3 -> src0 forwards from MEM
    step(1, 0, 0, 2'b00, 1, 0, 1, 1, 0, 0, 0);
    step(1, 1, 3, 2'b11, 1, 0, 2, 1, 0, 0, 1);

    // LDR r4 ; ADD r5,r4,r4 -> one stall then both sources from WB
    step(1, 0, 0, 2'b00, 1, 1, 4, 1, 0, 0, 0);
    step(1, 4, 4, 2'b11, 1, 0, 5, 1, 0, 1, 0);
    step(1, 4, 4, 2'b11, 1, 0, 5, 1, 0, 0, 10);
    check_val("ld_use_cnt", int'(hz_if.stall_cnt), 1);

    // producer r6, one independent, consumer -> WB forward
    step(1, 0, 0, 2'b00, 1, 0, 6, 1, 0, 0, 0);
    step(1, 7, 8, 2'b00, 1, 0, 9, 1, 0, 0, 0);
    step(1, 6, 0, 2'b01, 1, 0, 7, 1, 0, 0, 2);
    // producer r6, two independents, consumer -> register file
    step(1, 0, 0, 2'b00, 1, 0, 6, 1, 0, 0, 0);
    step(1, 0, 0, 2'b00, 1, 0, 10, 1, 0, 0, 0);
    step(1, 0, 0, 2'b00, 1, 0, 11, 1, 0, 0, 0);
    step(1, 6, 0, 2'b01, 1, 0, 12, 1, 0, 0, 0);

    // stall-only mode: two stall cycles then issue with RF select
    do_reset();
    step(1, 0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 2'b01, 1, 0, 2, 0, 0, 1, 0);
    step(1, 1, 0, 2'b01, 1, 0, 2, 0, 0, 1, 0);
    step(1, 1, 0, 2'b01, 1, 0, 2, 0, 0, 0, 0);
    check_val("nofwd_cnt", int'(hz_if.stall_cnt), 2);

    // flush wins over a hazard; unused sources never match
    do_reset();
    step(1, 0, 0, 2'b00, 1, 1, 1, 1, 0, 0, 0);
    step(1, 1, 0, 2'b01, 1, 0, 2, 1, 1, 0, 0);
    step(1, 0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0);
    step(1, 1, 3, 2'b10, 1, 0, 2, 0, 0, 0, 0);
    check_val("flush_cnt", int'(hz_if.stall_cnt), 0);

    // reset asserted during a load-use stall
    do_reset();
    step(1, 0, 0, 2'b00, 1, 0, 1, 1, 0, 0, 0);
    step(1, 1, 0, 2'b01, 1, 1, 4, 1, 0, 0, 1);
    drive(1, 4, 0, 2'b01, 1, 0, 5, 1, 0);
    #1;
    check_val("pre_rst_stall", int'(hz_if.stall), 1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_stall", int'(hz_if.stall), 0);
    check_val("mid_rst_sel", int'(hz_if.exe_sel_src), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // counter saturation: 16 stalls into a 4-bit counter, then more
    do_reset();
    for (int rep = 0; rep < 9; rep++) begin
      step(1, 0, 0, 2'b00, 1, 0, 1, 0, 0, 0, -1);
      for (int c = 0; c < 3; c++) step(1, 1, 0, 2'b01, 1, 0, 2, 0, 0, (c < 2) ? 1 : 0, -1);
      if (rep == 7) check_val("sat_cnt", int'(hz_if.stall_cnt), 15);
    end
    check_val("sat_hold", int'(hz_if.stall_cnt), 15);

    // random traffic over a small register set to provoke hazards
    do_reset();
    for (int n = 0; n < 600; n++) begin
      step(($urandom % 8) != 0, AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
           2'($urandom), ($urandom % 4) != 0, ($urandom % 3) == 0, AW'($urandom_range(0, 3)),
           ($urandom % 4) != 0, ($urandom % 10) == 0, -1, -1);
      if (n == 300) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
